md_sched: RTL
=============

// Module: md_sched
// PURPOSE
//   Multi-cycle multiply/divide scheduler for the 5-stage MIPS pipeline.
//   - Accepts MD ops from the E stage and holds a busy countdown.
//   - Owns the HI/LO registers.
//   - Drives the stall request that freezes the F/D pipeline registers (EN=0)
//     and clears the E register while a D-stage MD instruction must wait.
//   - md_out feeds the E-stage result mux (mfhi/mflo) and is carried down
//     to M_REG.
// PARAMETERS
//   MULT_LAT  5   busy cycles for mult/multu (and madd/msub)
//   DIV_LAT   10  busy cycles for div/divu
//   CNT_W     4   counter width; must satisfy 2**CNT_W > max(MULT_LAT, DIV_LAT)
// PORTS
//   clk       in   1   rising-edge clock
//   reset     in   1   synchronous, active-high reset
//   E_start   in   1   E-stage instruction is a valid MD op this cycle
//   E_md_op   in   4   op code (md_pkg::MD_*), qualified by E_start
//   E_rs      in   32  forwarded rs value
//   E_rt      in   32  forwarded rt value
//   D_use_md  in   1   D-stage instruction is any MD op (incl. mfhi/mflo/mthi/mtlo)
//   busy      out  1   a multi-cycle operation is in flight
//   stall     out  1   D_use_md & (busy | start of a mult/div this cycle)
//   md_out    out  32  HI if E_md_op==MD_MFHI, otherwise LO (combinational)
//   hi_q      out  32  HI register
//   lo_q      out  32  LO register
// BEHAVIOUR
//   Reset: busy=0, counter=0, hi_q=lo_q=0, staged result=0. Reset mid-operation
//     aborts the op; HI/LO stay 0. Nothing is written after reset.
//   States: IDLE, RUN.
//   IDLE -> RUN: E_start with a mult/div op. On that edge:
//     - counter loads LAT-1;
//     - the 64-bit result is computed from E_rs/E_rt and staged internally.
//   RUN:
//     - counter decrements every cycle;
//     - at counter==0, the staged result is written to HI/LO and the FSM
//       returns to IDLE.
//   busy timing: high exactly LAT cycles after the start edge. The first new
//     result is readable by mfhi/mflo in the cycle busy falls.
//   Start cycle: stall is asserted combinationally in the cycle E_start is high
//     for a mult/div op, even though busy is still 0.
//   mthi/mtlo: accepted only in IDLE; writes E_rs to HI or LO at the next edge
//     (one cycle). mfhi/mflo only read.
//   MD op presented while busy: ignored; no state change. The pipeline is
//     stalled, so this cannot occur legally.
//   Arithmetic:
//     - mult: signed 32x32 -> 64; multu: unsigned. HI = [63:32], LO = [31:0].
//     - div: signed; quotient truncates toward zero; remainder takes the sign
//       of the dividend. LO = quotient, HI = remainder.
//     - 0x80000000 / -1 gives LO=0x80000000, HI=0.
//     - Divide by zero (div/divu, rt==0): runs the full DIV_LAT cycles;
//       HI/LO are left unchanged.
//   Simultaneous events:
//     - The completion edge plus a new E_start with a mult/div op: the new op
//       is ignored, because busy is still 1 in that cycle.
//     - reset wins over everything.
// CONFIGURATION
//   MD_MADD_EN defined:
//     - enables MD_MADD and MD_MSUB: {HI,LO} <= {HI,LO} +/- signed(rs*rt),
//       modulo 2**64;
//     - latency MULT_LAT;
//     - the accumulator operand is sampled from HI/LO at the start edge.
//   MD_MADD_EN undefined: MD_MADD and MD_MSUB are treated as no-ops; busy
//     stays 0 and HI/LO are unchanged.
// STRUCTURE
//   md_pkg: MD_* op codes (NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI,
//     MFLO, MADD, MSUB) and default latency constants. Shared with the decoder
//     and hazard unit.
//   Sub-module md_arith: combinational 64-bit result from op/rs/rt/{HI,LO},
//     including the div-by-zero keep flag. md_sched holds only the FSM,
//     counter, staging register and HI/LO.
// TESTING
//   1. mult rs=3, rt=0xFFFFFFFE -> busy high 5 cycles; then HI=0xFFFFFFFF,
//      LO=0xFFFFFFFA.
//   2. divu rs=7, rt=2 -> busy 10 cycles; then LO=3, HI=1. With div rs=-7,
//      rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   3. D_use_md=1 in the start cycle and during the run -> stall=1 each cycle
//      until busy falls. D_use_md=0 -> stall=0 throughout.
//   4. div with rt=0 after mthi 0x11 / mtlo 0x22 -> after 10 cycles HI=0x11,
//      LO=0x22.
//   5. reset pulsed at cycle 3 of a div -> next cycle busy=0, HI=LO=0; a later
//      mult still runs correctly.
//   6. MD_MADD_EN: HI=0, LO=0xFFFFFFFF, madd 1*1 -> HI=1, LO=0. Without the
//      macro: busy stays 0 and HI/LO are unchanged.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg -- shared definitions for the multiply/divide unit.
//   Op codes (md_op_t) for the decoder, hazard unit and scheduler, the FSM
//   state type, default latencies and small op classification helpers.
//   Optional feature macro: MD_MADD_EN (madd/msub become multi-cycle ops).
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MSUB  = 4'd10
  } md_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_t;

  localparam int MD_MULT_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF  = 10;

  // Ops that occupy the unit for several cycles and write HI/LO at the end.
  function automatic logic md_is_long(input md_op_t op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_MADD_EN
      MD_MADD, MD_MSUB:                   return 1'b1;
`endif
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// md_sched_if -- E/D-stage to multiply/divide scheduler connection.
//   E_start/E_md_op/E_rs/E_rt : MD op issued from E stage with operands
//   D_use_md                  : D-stage instruction is any MD op
//   busy/stall                : unit in flight / freeze F,D and flush E
//   md_out/hi_q/lo_q          : mfhi/mflo result and the HI/LO registers
//   master = pipeline side, slave = scheduler side.
interface md_sched_if;
  import md_pkg::*;

  logic        E_start;
  md_op_t      E_md_op;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        D_use_md;
  logic        busy;
  logic        stall;
  logic [31:0] md_out;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  modport master (
    output E_start, E_md_op, E_rs, E_rt, D_use_md,
    input  busy, stall, md_out, hi_q, lo_q
  );

  modport slave (
    input  E_start, E_md_op, E_rs, E_rt, D_use_md,
    output busy, stall, md_out, hi_q, lo_q
  );
endinterface

// File: rtl/md_arith.sv
// md_arith -- combinational 64-bit result for one MD op.
//   i_op        : op code
//   i_rs, i_rt  : operands
//   i_hi, i_lo  : current HI/LO (accumulator for madd/msub)
//   o_result    : {HI, LO} to be written at completion
//   o_keep      : divide by zero, HI/LO must be left unchanged
//   Optional feature macro: MD_MADD_EN.
module md_arith
  import md_pkg::*;
(
  input  md_op_t      i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_result,
  output logic        o_keep
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_sdiv;
  logic [31:0] w_num;
  logic [31:0] w_den;
  logic [31:0] w_den_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // Low 64 bits of the product of sign-extended operands is the signed product.
  assign w_prod_s = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
  assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

  // One unsigned divider serves both div and divu: signed division works on
  // magnitudes and fixes the signs afterwards. 0x80000000 / -1 falls out
  // naturally as magnitude 0x80000000 with a re-negation that wraps to itself.
  assign w_sdiv     = (i_op == MD_DIV);
  assign w_num      = (w_sdiv && i_rs[31]) ? -i_rs : i_rs;
  assign w_den      = (w_sdiv && i_rt[31]) ? -i_rt : i_rt;
  assign w_den_safe = (w_den == 32'd0) ? 32'd1 : w_den;
  assign w_q_mag    = w_num / w_den_safe;
  assign w_r_mag    = w_num % w_den_safe;
  assign w_quot     = (w_sdiv && (i_rs[31] ^ i_rt[31])) ? -w_q_mag : w_q_mag;
  assign w_rem      = (w_sdiv && i_rs[31]) ? -w_r_mag : w_r_mag;

  assign o_keep = md_is_div(i_op) && (i_rt == 32'd0);

`ifdef MD_MADD_EN
  logic [63:0] w_acc;
  assign w_acc = {i_hi, i_lo};
`else
  logic w_unused_acc;
  assign w_unused_acc = ^{i_hi, i_lo};
`endif

  always_comb begin
    o_result = 64'd0;
    case (i_op)
      MD_MULT:        o_result = w_prod_s;
      MD_MULTU:       o_result = w_prod_u;
      MD_DIV, MD_DIVU: o_result = {w_rem, w_quot};
`ifdef MD_MADD_EN
      MD_MADD:        o_result = w_acc + w_prod_s;
      MD_MSUB:        o_result = w_acc - w_prod_s;
`endif
      default:        o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// md_sched -- multi-cycle multiply/divide scheduler with HI/LO registers.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   md     : md_sched_if.slave (E-stage op in, busy/stall/md_out/HI/LO out)
//   The result is computed at the start edge and staged; the counter only
//   models the latency. HI/LO are written when the counter reaches zero.
//   Requires 2**CNT_W > max(MULT_LAT, DIV_LAT).
//   Optional feature macro: MD_MADD_EN (madd/msub, latency MULT_LAT).
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT_DEF,
  parameter int DIV_LAT  = MD_DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic      clk,
  input  logic      reset,
  md_sched_if.slave md
);

  localparam logic [CNT_W-1:0] L_MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] L_DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  md_state_t        r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [63:0]      r_stage, w_stage_next;
  logic             r_keep, w_keep_next;
  logic [31:0]      r_hi, w_hi_next;
  logic [31:0]      r_lo, w_lo_next;

  logic [63:0]      w_result;
  logic             w_keep;
  logic             w_long;

  md_arith u_arith (
    .i_op     (md.E_md_op),
    .i_rs     (md.E_rs),
    .i_rt     (md.E_rt),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_result (w_result),
    .o_keep   (w_keep)
  );

  assign w_long = md.E_start && md_is_long(md.E_md_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_stage <= 64'd0;
      r_keep  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_stage <= w_stage_next;
      r_keep  <= w_keep_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
    end
  end

  // Any op arriving in RUN is dropped: the pipeline is stalled, so it is
  // never legal, and the completion-edge case is covered by the same rule.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_stage_next = r_stage;
    w_keep_next  = r_keep;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (w_long) begin
          w_state_next = S_RUN;
          w_cnt_next   = md_is_div(md.E_md_op) ? L_DIV_LOAD : L_MULT_LOAD;
          w_stage_next = w_result;
          w_keep_next  = w_keep;
        end else if (md.E_start && (md.E_md_op == MD_MTHI)) begin
          w_hi_next = md.E_rs;
        end else if (md.E_start && (md.E_md_op == MD_MTLO)) begin
          w_lo_next = md.E_rs;
        end
      end
      S_RUN: begin
        if (r_cnt == '0) begin
          w_state_next = S_IDLE;
          if (!r_keep) begin
            w_hi_next = r_stage[63:32];
            w_lo_next = r_stage[31:0];
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign md.busy   = (r_state == S_RUN);
  // The start term covers the issue cycle, before busy has risen.
  assign md.stall  = md.D_use_md && (md.busy || w_long);
  assign md.md_out = (md.E_md_op == MD_MFHI) ? r_hi : r_lo;
  assign md.hi_q   = r_hi;
  assign md.lo_q   = r_lo;

endmodule
